hpm_counter_unit: RTL and testbench

Parametrised machine-mode performance-monitor CSR block. Provides mcycle, minstret, NUM_COUNTERS programmable mhpmcounters with event selectors, mcountinhibit, mcounteren, and per-counter overflow flags that drive an interrupt. Sits beside the core CSR file. Owns the B00-B1F, C00-C1F, 320-33F and 306 CSR address windows. Event pulses come from the pipeline, and reads return one cycle after the request.

---
 rtl/hpm_counter_unit.sv | 141 ++++++++++++++
 tb/tb_hpm_counter_unit.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpm_counter_unit.sv
// rtl/hpm_counter_unit.sv - machine-mode performance-monitor CSR block
// mcycle/minstret/mhpmcounters with event selects, inhibit, counteren and overflow irq.
module hpm_counter_unit #(
  parameter int DATA_WIDTH    = 64,
  parameter int COUNTER_WIDTH = 64,
  parameter int NUM_COUNTERS  = 8,
  parameter int NUM_EVENTS    = 16,
  parameter int RETIRE_WIDTH  = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   csr_req,
  input  logic [11:0]                            csr_addr,
  input  logic [1:0]                             csr_op,
  input  logic [DATA_WIDTH-1:0]                  csr_wdata,
  input  logic                                   priv_user,
  output logic                                   csr_rvalid,
  output logic [DATA_WIDTH-1:0]                  csr_rdata,
  output logic                                   csr_error,
  input  logic [$clog2(RETIRE_WIDTH+1)-1:0]      retire_cnt,
  input  logic [NUM_EVENTS-1:0]                  event_pulse,
  output logic                                   irq_overflow
);

  // Index 0 = mcycle, 2 = minstret, 3.. = programmable counters; index 1 never exists.
  localparam logic [31:0] IMPL_MASK = 32'h0000_0005 | (((32'h1 << NUM_COUNTERS) - 32'h1) << 3);
  localparam logic [31:0] EVT_MASK  = IMPL_MASK & ~32'h0000_0007;
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

  logic [COUNTER_WIDTH-1:0] cnt     [32];
  logic [COUNTER_WIDTH-1:0] cnt_inc [32];
  logic [7:0]               ev_sel  [32];
  logic [31:0]              ev_of, ev_ofie, inhibit, counteren;

  logic [4:0]            idx;
  logic                  in_mcnt, in_ucnt, in_evt, is_en;
  logic                  impl_addr, acc_err, wr_en;
  logic [DATA_WIDTH-1:0] old_val, new_val;
  logic [31:0]           cnt_wr, evt_wr, hit, at_max, ovf;

  assign idx     = csr_addr[4:0];
  assign in_mcnt = (csr_addr[11:5] == 7'h58);
  assign in_ucnt = (csr_addr[11:5] == 7'h60);
  assign in_evt  = (csr_addr[11:5] == 7'h19);
  assign is_en   = (csr_addr == 12'h306);

  always_comb begin
    old_val   = '0;
    impl_addr = 1'b0;
    if (in_mcnt || in_ucnt) begin
      impl_addr = IMPL_MASK[idx];
      old_val   = DATA_WIDTH'(cnt[idx]);
    end else if (in_evt) begin
      if (idx == 5'd0) begin
        impl_addr = 1'b1;
        old_val   = DATA_WIDTH'(inhibit);
      end else begin
        impl_addr               = EVT_MASK[idx];
        old_val[DATA_WIDTH-1]   = ev_of[idx];
        old_val[DATA_WIDTH-2]   = ev_ofie[idx];
        old_val[7:0]            = ev_sel[idx];
      end
    end else if (is_en) begin
      impl_addr = 1'b1;
      old_val   = DATA_WIDTH'(counteren);
    end

    // User mode may only read the shadow window, and only where counteren allows.
    acc_err = !impl_addr
           || (in_ucnt && csr_op != 2'b00)
           || (priv_user && !in_ucnt)
           || (priv_user && in_ucnt && !counteren[idx]);
    wr_en   = csr_req && !acc_err && (csr_op != 2'b00);

    case (csr_op)
      2'b01:   new_val = csr_wdata;
      2'b10:   new_val = old_val | csr_wdata;
      2'b11:   new_val = old_val & ~csr_wdata;
      default: new_val = old_val;
    endcase
  end

  always_comb begin
    cnt_wr = '0;
    evt_wr = '0;
    hit    = '0;
    at_max = '0;
    for (int i = 0; i < 32; i++) begin
      cnt_wr[i] = wr_en && in_mcnt && (idx == 5'(i));
      evt_wr[i] = wr_en && in_evt && (idx == 5'(i));
      for (int k = 0; k < NUM_EVENTS; k++) begin
        if (ev_sel[i] == 8'(k + 1) && event_pulse[k]) hit[i] = 1'b1;
      end
      at_max[i] = (cnt[i] == CNT_MAX);
      if (i == 0)      cnt_inc[i] = COUNTER_WIDTH'(1);
      else if (i == 2) cnt_inc[i] = COUNTER_WIDTH'(retire_cnt);
      else             cnt_inc[i] = COUNTER_WIDTH'(hit[i]);
    end
    // A software write to the counter suppresses its increment, so it cannot wrap.
    ovf = hit & ~inhibit & at_max & ~cnt_wr & EVT_MASK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        cnt[i]    <= '0;
        ev_sel[i] <= '0;
      end
      ev_of        <= '0;
      ev_ofie      <= '0;
      inhibit      <= '0;
      counteren    <= '0;
      csr_rvalid   <= 1'b0;
      csr_rdata    <= '0;
      csr_error    <= 1'b0;
      irq_overflow <= 1'b0;
    end else begin
      csr_rvalid   <= csr_req;
      csr_error    <= csr_req && acc_err;
      csr_rdata    <= (csr_req && !acc_err) ? old_val : '0;
      irq_overflow <= |(ev_of & ev_ofie);
      for (int i = 0; i < 32; i++) begin
        if (IMPL_MASK[i]) begin
          if (cnt_wr[i])        cnt[i] <= new_val[COUNTER_WIDTH-1:0];
          else if (!inhibit[i]) cnt[i] <= cnt[i] + cnt_inc[i];
        end
        if (EVT_MASK[i]) begin
          if (evt_wr[i]) begin
            ev_sel[i]  <= new_val[7:0];
            ev_ofie[i] <= new_val[DATA_WIDTH-2];
          end
          // Hardware overflow beats a same-cycle software clear of OF.
          ev_of[i] <= (evt_wr[i] ? new_val[DATA_WIDTH-1] : ev_of[i]) | ovf[i];
        end
      end
      if (wr_en && in_evt && idx == 5'd0) inhibit <= new_val[31:0] & IMPL_MASK;
      if (wr_en && is_en) counteren <= new_val[31:0] & IMPL_MASK;
    end
  end

endmodule

// File: tb/tb_hpm_counter_unit.sv
// tb/tb_hpm_counter_unit.sv - directed and random checks of hpm_counter_unit
// Reference model keeps plain integer counters and applies the CSR rules per cycle.
module tb_hpm_counter_unit;

  localparam int NC = 8;
  localparam int NE = 16;
  localparam logic [1:0] OP_RD = 2'b00, OP_WR = 2'b01, OP_SET = 2'b10, OP_CLR = 2'b11;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_req;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [63:0] csr_wdata;
  logic        priv_user;
  logic        csr_rvalid;
  logic [63:0] csr_rdata;
  logic        csr_error;
  logic [1:0]  retire_cnt;
  logic [15:0] event_pulse;
  logic        irq_overflow;

  int n_assert = 0;
  int n_fail   = 0;

  longint unsigned m_cnt [32];
  int              m_sel [32];
  bit [31:0]       m_of, m_ofie, m_inh, m_en;
  logic [63:0]     m_rdata;
  logic            m_rvalid, m_err, m_irq;

  logic [11:0] addr_tab [0:21] = '{12'hB00, 12'hB01, 12'hB02, 12'hB03, 12'hB05, 12'hB0A, 12'hB0B,
                                   12'hB1F, 12'hC00, 12'hC02, 12'hC03, 12'hC0A, 12'hC0B, 12'h320,
                                   12'h321, 12'h322, 12'h323, 12'h324, 12'h32A, 12'h32B, 12'h306,
                                   12'h123};

  hpm_counter_unit #(
    .DATA_WIDTH(64), .COUNTER_WIDTH(64), .NUM_COUNTERS(NC), .NUM_EVENTS(NE), .RETIRE_WIDTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .csr_req(csr_req), .csr_addr(csr_addr), .csr_op(csr_op),
    .csr_wdata(csr_wdata), .priv_user(priv_user), .csr_rvalid(csr_rvalid), .csr_rdata(csr_rdata),
    .csr_error(csr_error), .retire_cnt(retire_cnt), .event_pulse(event_pulse),
    .irq_overflow(irq_overflow)
  );

  always #5 clk = ~clk;

  function automatic bit cnt_impl(input int i);
    return (i == 0) || (i == 2) || (i >= 3 && i < 3 + NC);
  endfunction

  function automatic logic [63:0] mread(input logic [11:0] a, input logic [1:0] o,
                                        input logic u, output logic err);
    int ai, i;
    bit impl, uwin;
    logic [63:0] v;
    ai   = int'(a);
    i    = ai % 32;
    v    = '0;
    impl = 1'b0;
    uwin = (ai >= 'hC00 && ai <= 'hC1F);
    if ((ai >= 'hB00 && ai <= 'hB1F) || uwin) begin
      impl = cnt_impl(i);
      v    = m_cnt[i];
    end else if (ai >= 'h320 && ai <= 'h33F) begin
      if (i == 0) begin
        impl = 1'b1;
        v    = 64'(m_inh);
      end else if (i >= 3 && i < 3 + NC) begin
        impl = 1'b1;
        v    = {m_of[i], m_ofie[i], 54'd0, 8'(m_sel[i])};
      end
    end else if (ai == 'h306) begin
      impl = 1'b1;
      v    = 64'(m_en);
    end
    err = !impl || (uwin && o != OP_RD) || (u && !uwin) || (u && uwin && !m_en[i]);
    return err ? 64'd0 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_cnt[i] = 0;
      m_sel[i] = 0;
    end
    m_of = 0; m_ofie = 0; m_inh = 0; m_en = 0;
    m_rdata = 0; m_rvalid = 0; m_err = 0; m_irq = 0;
  endtask

  task automatic model_step();
    logic        err;
    logic [63:0] v, wv;
    bit          wr, irq_n;
    bit [31:0]   hw, inh, mask;
    if (!rst_n) begin
      model_reset();
      return;
    end
    v  = mread(csr_addr, csr_op, priv_user, err);
    wr = csr_req && !err && csr_op != OP_RD;
    if (csr_op == OP_WR)       wv = csr_wdata;
    else if (csr_op == OP_SET) wv = v | csr_wdata;
    else                       wv = v & ~csr_wdata;
    irq_n = |(m_of & m_ofie);
    inh   = m_inh;
    hw    = 0;
    mask  = 0;
    for (int i = 0; i < 32; i++) begin
      longint unsigned inc;
      if (cnt_impl(i)) begin
        mask[i] = 1'b1;
        if (wr && int'(csr_addr) == 'hB00 + i) m_cnt[i] = wv;
        else if (!inh[i]) begin
          inc = 0;
          if (i == 0) inc = 1;
          else if (i == 2) inc = longint'(retire_cnt);
          else if (m_sel[i] >= 1 && m_sel[i] <= NE && event_pulse[m_sel[i] - 1]) inc = 1;
          if (i >= 3 && inc == 1 && m_cnt[i] == ONES) hw[i] = 1'b1;
          m_cnt[i] = m_cnt[i] + inc;
        end
      end
    end
    for (int i = 3; i < 3 + NC; i++) begin
      if (wr && int'(csr_addr) == 'h320 + i) begin
        m_sel[i]  = int'(wv[7:0]);
        m_of[i]   = wv[63];
        m_ofie[i] = wv[62];
      end
    end
    m_of = m_of | hw;
    if (wr && csr_addr == 12'h320) m_inh = wv[31:0] & mask;
    if (wr && csr_addr == 12'h306) m_en  = wv[31:0] & mask;
    m_rvalid = csr_req;
    m_err    = csr_req && err;
    m_rdata  = (csr_req && !err) ? v : 64'd0;
    m_irq    = irq_n;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      check("rvalid_idle", 64'(csr_rvalid), 64'd0);
      check("irq", 64'(irq_overflow), 64'(m_irq));
    end
  endtask

  task automatic csr(input logic [1:0] o, input logic [11:0] a, input logic [63:0] wd,
                     input logic u, output logic [63:0] rd, output logic er);
    csr_req = 1'b1; csr_addr = a; csr_op = o; csr_wdata = wd; priv_user = u;
    tick();
    csr_req = 1'b0; priv_user = 1'b0;
    check("rvalid", 64'(csr_rvalid), 64'd1);
    check($sformatf("rdata_%h", a), csr_rdata, m_rdata);
    check($sformatf("error_%h", a), 64'(csr_error), 64'(m_err));
    check("irq", 64'(irq_overflow), 64'(m_irq));
    rd = csr_rdata;
    er = csr_error;
  endtask

  initial begin
    logic [63:0] rd, wd;
    logic        er;
    rst_n = 1'b0; csr_req = 1'b0; csr_addr = '0; csr_op = '0; csr_wdata = '0;
    priv_user = 1'b0; retire_cnt = '0; event_pulse = '0;
    model_reset();
    tick();
    tick();
    check("rst_rvalid", 64'(csr_rvalid), 64'd0);
    check("rst_rdata", csr_rdata, 64'd0);
    check("rst_error", 64'(csr_error), 64'd0);
    check("rst_irq", 64'(irq_overflow), 64'd0);

    // Idle counting of mcycle and minstret.
    rst_n = 1'b1;
    retire_cnt = 2'd2;
    idle(10);
    csr(OP_RD, 12'hB00, 0, 0, rd, er);
    check("mcycle_10", rd, 64'd10);
    csr(OP_RD, 12'hB02, 0, 0, rd, er);
    check("minstret_22", rd, 64'd22);
    retire_cnt = 2'd0;
    idle(1);

    // Event counting while counter 4 inhibit toggles.
    csr(OP_WR, 12'h323, 64'd5, 0, rd, er);
    event_pulse = 16'h0010;
    for (int c = 0; c < 7; c++) begin
      if (c == 2)      csr(OP_SET, 12'h320, 64'h10, 0, rd, er);
      else if (c == 4) csr(OP_CLR, 12'h320, 64'h10, 0, rd, er);
      else             idle(1);
    end
    event_pulse = 16'h0;
    csr(OP_RD, 12'hB03, 0, 0, rd, er);
    check("hpm3_7", rd, 64'd7);
    csr(OP_RD, 12'hB04, 0, 0, rd, er);
    check("hpm4_0", rd, 64'd0);

    // Overflow and interrupt.
    csr(OP_WR, 12'h323, 64'h4000_0000_0000_0005, 0, rd, er);
    event_pulse = 16'h0010;
    csr(OP_WR, 12'hB03, ONES, 0, rd, er);
    idle(1);
    check("irq_not_yet", 64'(irq_overflow), 64'd0);
    event_pulse = 16'h0;
    idle(1);
    check("irq_set", 64'(irq_overflow), 64'd1);
    csr(OP_RD, 12'h323, 0, 0, rd, er);
    check("of_set", rd, 64'hC000_0000_0000_0005);
    csr(OP_RD, 12'hB03, 0, 0, rd, er);
    check("hpm3_wrapped", rd, 64'd0);
    csr(OP_CLR, 12'h323, 64'h8000_0000_0000_0000, 0, rd, er);
    check("irq_still", 64'(irq_overflow), 64'd1);
    idle(1);
    check("irq_drop", 64'(irq_overflow), 64'd0);

    // Software clear collides with hardware overflow.
    csr(OP_WR, 12'hB03, ONES, 0, rd, er);
    event_pulse = 16'h0010;
    csr(OP_CLR, 12'h323, 64'h8000_0000_0000_0000, 0, rd, er);
    event_pulse = 16'h0;
    csr(OP_RD, 12'h323, 0, 0, rd, er);
    check("of_wins", rd, 64'hC000_0000_0000_0005);
    csr(OP_CLR, 12'h323, 64'hC000_0000_0000_0000, 0, rd, er);
    idle(2);

    // Write wins over same-cycle increment, then set.
    csr(OP_WR, 12'h325, 64'd5, 0, rd, er);
    event_pulse = 16'h0010;
    csr(OP_WR, 12'hB05, 64'h100, 0, rd, er);
    event_pulse = 16'h0;
    csr(OP_RD, 12'hB05, 0, 0, rd, er);
    check("hpm5_written", rd, 64'h100);
    csr(OP_SET, 12'hB05, 64'h3, 0, rd, er);
    check("hpm5_set_old", rd, 64'h100);
    csr(OP_RD, 12'hB05, 0, 0, rd, er);
    check("hpm5_set", rd, 64'h103);

    // User-mode shadow access.
    csr(OP_RD, 12'hC03, 0, 1, rd, er);
    check("u_c03_err", 64'(er), 64'd1);
    check("u_c03_rdata", rd, 64'd0);
    csr(OP_SET, 12'h306, 64'h8, 0, rd, er);
    csr(OP_RD, 12'hB03, 0, 0, wd, er);
    csr(OP_RD, 12'hC03, 0, 1, rd, er);
    check("u_c03_ok", 64'(er), 64'd0);
    check("u_c03_val", rd, wd);
    csr(OP_WR, 12'hC00, 64'd5, 1, rd, er);
    check("u_c00_wr_err", 64'(er), 64'd1);
    csr(OP_RD, 12'hB00, 0, 1, rd, er);
    check("u_b00_err", 64'(er), 64'd1);
    csr(OP_WR, 12'hC00, 64'd5, 0, rd, er);
    check("m_c00_wr_err", 64'(er), 64'd1);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      event_pulse = 16'($urandom);
      retire_cnt  = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 3))
          0:       wd = ONES - 64'($urandom_range(0, 3));
          1:       wd = {$urandom, $urandom};
          2:       wd = 64'($urandom_range(0, 255));
          default: wd = 64'hC000_0000_0000_0000 | 64'($urandom_range(0, 20));
        endcase
        csr(2'($urandom), addr_tab[$urandom_range(0, 21)], wd, ($urandom_range(0, 3) == 0), rd, er);
      end else begin
        idle(1);
      end
    end
    event_pulse = 16'h0;
    retire_cnt  = 2'd0;
    csr(OP_WR, 12'h320, 64'd0, 0, rd, er);
    for (int i = 0; i < 11; i++) csr(OP_RD, 12'hB00 + 12'(i), 0, 0, rd, er);
    for (int i = 3; i < 11; i++) csr(OP_RD, 12'h320 + 12'(i), 0, 0, rd, er);

    // Unimplemented addresses.
    csr(OP_WR, 12'hB1F, 64'd7, 0, rd, er);
    check("b1f_err", 64'(er), 64'd1);
    csr(OP_RD, 12'hB01, 0, 0, rd, er);
    check("b01_err", 64'(er), 64'd1);
    csr(OP_WR, 12'h321, 64'd7, 0, rd, er);
    check("321_err", 64'(er), 64'd1);
    csr(OP_RD, 12'hB0B, 0, 0, rd, er);
    check("b0b_err", 64'(er), 64'd1);
    csr(OP_RD, 12'hB0A, 0, 0, rd, er);
    check("b0a_ok", 64'(er), 64'd0);

    // Asynchronous reset mid-count.
    csr(OP_WR, 12'h323, 64'hC000_0000_0000_0005, 0, rd, er);
    idle(1);
    check("irq_pre_rst", 64'(irq_overflow), 64'd1);
    event_pulse = 16'hFFFF;
    retire_cnt  = 2'd2;
    idle(3);
    rst_n = 1'b0;
    #1;
    check("arst_irq", 64'(irq_overflow), 64'd0);
    check("arst_rvalid", 64'(csr_rvalid), 64'd0);
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    event_pulse = 16'h0;
    retire_cnt  = 2'd0;
    csr(OP_RD, 12'hB03, 0, 0, rd, er);
    check("arst_hpm3", rd, 64'd0);
    csr(OP_RD, 12'hB02, 0, 0, rd, er);
    check("arst_minstret", rd, 64'd0);
    csr(OP_RD, 12'hB00, 0, 0, rd, er);
    check("arst_mcycle", rd, 64'd2);
    csr(OP_RD, 12'h323, 0, 0, rd, er);
    check("arst_evt3", rd, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
